// File: rtl/multi_edge_detector.sv
// Multi-channel edge detector: per-channel synchroniser, stability filter, registered
// rise/fall/mode-selected pulses, sticky event flags and saturating edge counters.
module multi_edge_detector #(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_CYC    = 3,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       din,
    input  logic [1:0]             mode,
    input  logic [WIDTH-1:0]       clr,
    input  logic [WIDTH-1:0]       cnt_clr,
    output logic [WIDTH-1:0]       level,
    output logic [WIDTH-1:0]       rise_pulse,
    output logic [WIDTH-1:0]       fall_pulse,
    output logic [WIDTH-1:0]       edge_pulse,
    output logic [WIDTH-1:0]       sticky,
    output logic [WIDTH*CNT_W-1:0] edge_cnt
);

    localparam logic [7:0]       STAB_LAST = 8'(FILT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q, sync_d;
        logic                   sync_out;
        logic [7:0]             stab_q, stab_d;
        logic                   level_q, level_d;
        logic                   rise_q, rise_d;
        logic                   fall_q, fall_d;
        logic                   edge_q, edge_d;
        logic                   sticky_q, sticky_d;
        logic [CNT_W-1:0]       cnt_q, cnt_d;

        assign sync_out = sync_q[SYNC_STAGES-1];

        always_comb begin
            sync_d   = {sync_q[SYNC_STAGES-2:0], din[i]};
            stab_d   = stab_q;
            level_d  = level_q;
            rise_d   = 1'b0;
            fall_d   = 1'b0;

            // A new level is accepted only after FILT_CYC consecutive mismatching samples.
            if (sync_out == level_q) begin
                stab_d = '0;
            end else if (stab_q == STAB_LAST) begin
                level_d = sync_out;
                stab_d  = '0;
                rise_d  = sync_out;
                fall_d  = ~sync_out;
            end else begin
                stab_d = stab_q + 8'd1;
            end

            edge_d   = (rise_d & mode[0]) | (fall_d & mode[1]);
            // Set wins over clear so an event coinciding with clr is never lost.
            sticky_d = edge_q | (sticky_q & ~clr[i]);

            if (cnt_clr[i]) begin
                cnt_d = edge_q ? CNT_W'(1) : '0;
            end else if (edge_q && (cnt_q != CNT_MAX)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else begin
                cnt_d = cnt_q;
            end
        end

        always_ff @(posedge clk) begin
            if (!rst) begin
                sync_q   <= '0;
                stab_q   <= '0;
                level_q  <= 1'b0;
                rise_q   <= 1'b0;
                fall_q   <= 1'b0;
                edge_q   <= 1'b0;
                sticky_q <= 1'b0;
                cnt_q    <= '0;
            end else begin
                sync_q   <= sync_d;
                stab_q   <= stab_d;
                level_q  <= level_d;
                rise_q   <= rise_d;
                fall_q   <= fall_d;
                edge_q   <= edge_d;
                sticky_q <= sticky_d;
                cnt_q    <= cnt_d;
            end
        end

        assign level[i]                     = level_q;
        assign rise_pulse[i]                = rise_q;
        assign fall_pulse[i]                = fall_q;
        assign edge_pulse[i]                = edge_q;
        assign sticky[i]                    = sticky_q;
        assign edge_cnt[i*CNT_W +: CNT_W]   = cnt_q;
    end

endmodule

// File: tb/tb_multi_edge_detector.sv
// Bench for multi_edge_detector: directed scenarios then random traffic, every cycle
// checked against a history-based reference model (8-bit and 2-bit counter instances).
module tb_multi_edge_detector;

    localparam int W   = 4;
    localparam int SS  = 2;
    localparam int FC  = 3;
    localparam int CW  = 8;
    localparam int CW2 = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [W-1:0]  din, clr, cnt_clr;
    logic [1:0]    mode;

    logic [W-1:0]    level, rise_pulse, fall_pulse, edge_pulse, sticky;
    logic [W*CW-1:0] edge_cnt;
    logic [W-1:0]    level2, rise2, fall2, edge2, sticky2;
    logic [W*CW2-1:0] edge_cnt2;

    multi_edge_detector #(.WIDTH(W), .SYNC_STAGES(SS), .FILT_CYC(FC), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .din(din), .mode(mode), .clr(clr), .cnt_clr(cnt_clr),
        .level(level), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
        .edge_pulse(edge_pulse), .sticky(sticky), .edge_cnt(edge_cnt)
    );

    multi_edge_detector #(.WIDTH(W), .SYNC_STAGES(SS), .FILT_CYC(FC), .CNT_W(CW2)) dut_c2 (
        .clk(clk), .rst(rst), .din(din), .mode(mode), .clr(clr), .cnt_clr(cnt_clr),
        .level(level2), .rise_pulse(rise2), .fall_pulse(fall2),
        .edge_pulse(edge2), .sticky(sticky2), .edge_cnt(edge_cnt2)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: sync_out is din seen SS edges ago; a level is accepted when the
    // last FC sync_out samples all differ from the current level.
    bit [W-1:0] m_chain [SS];
    bit [W-1:0] m_hist  [FC];
    bit [W-1:0] m_level, m_rise, m_fall, m_edge, m_sticky;
    int         m_cnt  [W];
    int         m_cnt2 [W];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_edge();
        bit [W-1:0] so;
        bit [W-1:0] acc;
        if (!rst) begin
            for (int k = 0; k < SS; k++) m_chain[k] = '0;
            for (int k = 0; k < FC; k++) m_hist[k] = '0;
            m_level = '0; m_rise = '0; m_fall = '0; m_edge = '0; m_sticky = '0;
            for (int i = 0; i < W; i++) begin
                m_cnt[i]  = 0;
                m_cnt2[i] = 0;
            end
        end else begin
            so = m_chain[SS-1];
            for (int k = FC - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
            m_hist[0] = so;
            acc = '1;
            for (int k = 0; k < FC; k++) acc &= m_hist[k] ^ m_level;
            m_sticky = m_edge | (m_sticky & ~clr);
            for (int i = 0; i < W; i++) begin
                if (cnt_clr[i]) begin
                    m_cnt[i]  = m_edge[i] ? 1 : 0;
                    m_cnt2[i] = m_edge[i] ? 1 : 0;
                end else if (m_edge[i]) begin
                    if (m_cnt[i] < (1 << CW) - 1) m_cnt[i]++;
                    if (m_cnt2[i] < (1 << CW2) - 1) m_cnt2[i]++;
                end
            end
            m_rise  = acc & so;
            m_fall  = acc & ~so;
            m_edge  = (m_rise & {W{mode[0]}}) | (m_fall & {W{mode[1]}});
            m_level = (m_level & ~acc) | (so & acc);
            for (int k = SS - 1; k > 0; k--) m_chain[k] = m_chain[k-1];
            m_chain[0] = din;
        end
    endtask

    task automatic compare_all();
        logic [W*CW-1:0]  e8;
        logic [W*CW2-1:0] e2;
        for (int i = 0; i < W; i++) begin
            e8[i*CW +: CW]   = CW'(m_cnt[i]);
            e2[i*CW2 +: CW2] = CW2'(m_cnt2[i]);
        end
        chk("level", 64'(level), 64'(m_level));
        chk("rise_pulse", 64'(rise_pulse), 64'(m_rise));
        chk("fall_pulse", 64'(fall_pulse), 64'(m_fall));
        chk("edge_pulse", 64'(edge_pulse), 64'(m_edge));
        chk("sticky", 64'(sticky), 64'(m_sticky));
        chk("edge_cnt", 64'(edge_cnt), 64'(e8));
        chk("edge_cnt_w2", 64'(edge_cnt2), 64'(e2));
        chk("flags_w2", 64'({level2, rise2, fall2, edge2, sticky2}),
            64'({m_level, m_rise, m_fall, m_edge, m_sticky}));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, 64'({level, rise_pulse, fall_pulse, edge_pulse, sticky}), 64'(0));
        chk({tag, "_cnt"}, 64'(edge_cnt), 64'(0));
        chk({tag, "_cnt2"}, 64'(edge_cnt2), 64'(0));
    endtask

    int exp_c [5] = '{1, 2, 3, 3, 3};

    initial begin
        rst = 1'b0; din = '0; mode = 2'b00; clr = '0; cnt_clr = '0;
        steps(3);
        chk_all_zero("reset_state");
        rst = 1'b1;
        steps(2);

        // Clean rise on ch0, pulse on the 5th edge, then sticky set-wins-over-clr.
        mode = 2'b01;
        din[0] = 1'b1;
        steps(4);
        chk("rise_before_5th", 64'(rise_pulse[0]), 64'(0));
        step();
        chk("rise_on_5th", 64'(rise_pulse[0]), 64'(1));
        chk("edge_on_5th", 64'(edge_pulse[0]), 64'(1));
        clr[0] = 1'b1;
        step();
        chk("sticky_set_wins", 64'(sticky[0]), 64'(1));
        chk("cnt0_one", 64'(edge_cnt[0 +: CW]), 64'(1));
        chk("rise_one_cycle", 64'(rise_pulse[0]), 64'(0));
        step();
        chk("sticky_cleared", 64'(sticky[0]), 64'(0));
        clr[0] = 1'b0;
        steps(4);

        // 2-cycle glitch on ch1 is rejected.
        din[1] = 1'b1;
        steps(2);
        din[1] = 1'b0;
        steps(8);
        chk("glitch_level", 64'(level[1]), 64'(0));
        chk("glitch_cnt", 64'(edge_cnt[1*CW +: CW]), 64'(0));

        // Falling-only mode on ch2.
        mode = 2'b10;
        din[2] = 1'b1;
        steps(8);
        din[2] = 1'b0;
        steps(8);
        chk("fall_mode_cnt", 64'(edge_cnt[2*CW +: CW]), 64'(1));

        // Both edges on ch3; 2-bit counter saturates, then clear coinciding with an event.
        mode = 2'b11;
        for (int t = 0; t < 5; t++) begin
            din[3] = ~din[3];
            steps(8);
            chk("sat_cnt", 64'(edge_cnt2[3*CW2 +: CW2]), 64'(exp_c[t]));
        end
        din[3] = ~din[3];
        steps(5);
        cnt_clr[3] = 1'b1;
        step();
        cnt_clr[3] = 1'b0;
        chk("clr_with_event_w2", 64'(edge_cnt2[3*CW2 +: CW2]), 64'(1));
        chk("clr_with_event_w8", 64'(edge_cnt[3*CW +: CW]), 64'(1));
        steps(2);

        // Reset mid-filter discards a pending rise; held input rises after release.
        din = '0;
        steps(10);
        din[0] = 1'b1;
        steps(3);
        rst = 1'b0;
        step();
        chk_all_zero("midfilter_reset");
        rst = 1'b1;
        steps(4);
        chk("post_rst_rise_early", 64'(rise_pulse[0]), 64'(0));
        step();
        chk("post_rst_rise_5th", 64'(rise_pulse[0]), 64'(1));
        steps(3);

        // Random traffic.
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < W; i++) begin
                if ($urandom_range(5) == 0) din[i] = ~din[i];
                clr[i]     = ($urandom_range(7) == 0);
                cnt_clr[i] = ($urandom_range(15) == 0);
            end
            if ($urandom_range(19) == 0) mode = 2'($urandom_range(3));
            rst = ($urandom_range(199) != 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multi_edge_detector.md
MULTI_EDGE_DETECTOR -- requirements
Module: multi_edge_detector

Interface
REQ-001 Parameter WIDTH, default 4: number of independent input channels (1..32).
REQ-002 Parameter SYNC_STAGES, default 2: synchroniser flops per channel (2..4).
REQ-003 Parameter FILT_CYC, default 3: consecutive stable cycles required to accept a new level (1..255).
REQ-004 Parameter CNT_W, default 8: width of each per-channel edge counter (1..16).
REQ-005 clk  input  1: single clock; all state updates on its rising edge.
REQ-006 rst  input  1: reset, synchronous, active-low.
REQ-007 din  input  WIDTH: asynchronous raw channel inputs.
REQ-008 mode  input  2: event select; 00 none, 01 rising, 10 falling, 11 both.
REQ-009 clr  input  WIDTH: per-channel sticky clear, one bit per channel.
REQ-010 cnt_clr  input  WIDTH: per-channel counter clear.
REQ-011 level  output  WIDTH: filtered, synchronised channel level.
REQ-012 rise_pulse  output  WIDTH: one-cycle pulse on each filtered 0->1 transition, independent of mode.
REQ-013 fall_pulse  output  WIDTH: one-cycle pulse on each filtered 1->0 transition, independent of mode.
REQ-014 edge_pulse  output  WIDTH: one-cycle pulse on transitions selected by mode.
REQ-015 sticky  output  WIDTH: latched event flag per channel.
REQ-016 edge_cnt  output  WIDTH*CNT_W: packed counters; channel i occupies bits [i*CNT_W +: CNT_W].

Function
REQ-017 Each din bit SHALL pass through a SYNC_STAGES-deep flop chain; sync_out is the last stage.
REQ-018 The per-channel filter SHALL track stab_cnt: sync_out==level -> stab_cnt<=0; otherwise stab_cnt==FILT_CYC-1 -> level<=sync_out, stab_cnt<=0; otherwise stab_cnt<=stab_cnt+1.
REQ-019 A sync_out excursion shorter than FILT_CYC cycles SHALL be rejected with no change to level and no pulse.
REQ-020 A din change held stable SHALL appear on level, and pulse, after the (SYNC_STAGES+FILT_CYC)th rising clk edge, counting the capturing edge as the 1st (5 edges at default parameters).
REQ-021 rise_pulse[i] and fall_pulse[i] SHALL be registered, high exactly one cycle, coincident with the first cycle of the new level[i] value; the two are never high together.
REQ-022 edge_pulse[i] SHALL equal (rise_pulse[i] & mode[0]) | (fall_pulse[i] & mode[1]), with mode sampled in the same cycle the transition is registered.
REQ-023 A mode change SHALL affect only transitions registered on later edges; already-registered pulses are unaffected.
REQ-024 sticky[i] SHALL set on edge_pulse[i] and hold until clr[i]; if set and clr coincide, sticky[i] is 1 on the next cycle (set wins).
REQ-025 edge_cnt channel i SHALL increment by 1 on each edge_pulse[i] and saturate at 2^CNT_W-1 with no wrap.
REQ-026 If cnt_clr[i] and edge_pulse[i] coincide, counter i SHALL become 1 (no lost event); cnt_clr alone -> 0.
REQ-027 Channels SHALL be fully independent; simultaneous events on several channels are each processed.
REQ-028 Back-to-back accepted transitions SHALL be spaced by at least FILT_CYC cycles, and each SHALL produce its own pulse.

Reset
REQ-029 While rst==0 at a clk edge, all synchroniser flops, stab_cnt, level, rise_pulse, fall_pulse, edge_pulse, sticky and edge_cnt SHALL be 0.
REQ-030 Reset asserted mid-filter SHALL discard the pending transition; no pulse is produced for it.
REQ-031 A din bit held at 1 through rst release SHALL produce a rise_pulse REQ-020 latency after the first capturing edge following release.

Verification
REQ-032 Defaults, mode=01: din[0] 0->1 held 10 cycles -> rise_pulse[0] and edge_pulse[0] high 1 cycle on the 5th edge; sticky[0]=1; edge_cnt[0]=1.
REQ-033 Glitch: din[1] high 2 cycles then low, FILT_CYC=3 -> level[1], pulses and edge_cnt[1] stay 0.
REQ-034 mode=10: din[2] 0->1->0, each level held 8 cycles -> rise_pulse[2]=1 and fall_pulse[2]=1, one pulse each; edge_pulse[2] only on the fall; edge_cnt[2]=1.
REQ-035 CNT_W=2, mode=11: 5 clean toggles on ch3 -> edge_cnt[3] reads 1,2,3,3,3; cnt_clr[3] together with the 6th pulse -> counter=1.
REQ-036 clr[0] asserted in the same cycle as edge_pulse[0] -> sticky[0]=1 next cycle; clr[0] alone next cycle -> sticky[0]=0.
REQ-037 rst=0 for 1 cycle at stab_cnt=1 of a pending rise -> no pulse; all outputs 0; din held high -> rise_pulse 5 edges after release.
